// File: rtl/fadd_pkg.sv
// ---------------------------------------------------------------------------
// fadd_pkg : constants and types shared by the single-precision adder back end.
//   - rounding-mode encodings (RM_RNE / RM_RTZ / RM_RDN / RM_RUP)
//   - FSM state encoding for fadd_norm
//   - IEEE single-precision field constants (EXP_MAX, BIAS)
// ---------------------------------------------------------------------------
package fadd_pkg;

  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int         BIAS    = 127;

  localparam logic [1:0] RM_RNE = 2'b00;  // round to nearest, ties to even
  localparam logic [1:0] RM_RTZ = 2'b01;  // round toward zero
  localparam logic [1:0] RM_RDN = 2'b10;  // round toward -inf
  localparam logic [1:0] RM_RUP = 2'b11;  // round toward +inf

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_NORM  = 2'b01,
    ST_ROUND = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/fadd_round.sv
// ---------------------------------------------------------------------------
// fadd_round : combinational rounding and packing for the adder back end.
// Ports:
//   frac     in  27-bit normalized mantissa {hidden, frac[22:0], G, R, S}
//   exp      in  biased exponent, two extra bits of headroom (0 = denormal)
//   sign     in  result sign (zero-result sign already resolved by caller)
//   rm       in  rounding mode (see fadd_pkg)
//   s        out packed IEEE result
//   inexact  out G|R|S nonzero before rounding
//   overflow out final exponent reached all-ones
// ---------------------------------------------------------------------------
module fadd_round
  import fadd_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [FRAC_W+3:0]      frac,
  input  logic [EXP_W+1:0]       exp,
  input  logic                   sign,
  input  logic [1:0]             rm,
  output logic [EXP_W+FRAC_W:0]  s,
  output logic                   inexact,
  output logic                   overflow
);

  localparam int XW = EXP_W + 2;
  localparam int MW = FRAC_W + 1;
  localparam logic [XW-1:0] ONE_X  = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0] ZERO_X = {XW{1'b0}};
  localparam logic [XW-1:0] MAX_X  = {2'b00, {EXP_W{1'b1}}};

  logic              g_s, rs_s, lsb_s, inc_s, to_inf_s;
  logic [MW:0]       sum_s;
  logic [XW-1:0]     exp_norm_s, exp_fin_s;
  logic [FRAC_W-1:0] frac_fin_s;

  // Round increment, mantissa add, exponent adjust and overflow packing.
  always_comb begin
    g_s   = frac[2];
    rs_s  = frac[1] | frac[0];
    lsb_s = frac[3];

    case (rm)
      RM_RNE:  inc_s = g_s & (rs_s | lsb_s);
      RM_RTZ:  inc_s = 1'b0;
      RM_RDN:  inc_s = sign & (g_s | rs_s);
      RM_RUP:  inc_s = ~sign & (g_s | rs_s);
      default: inc_s = 1'b0;
    endcase

    sum_s = {1'b0, frac[FRAC_W+3:3]} + {{MW{1'b0}}, inc_s};

    // A normal mantissa sitting at exponent 0 (denormal operands that carried
    // into the hidden bit) really lives at exponent 1.
    if (frac[FRAC_W+3]) begin
      exp_norm_s = (exp == ZERO_X) ? ONE_X : exp;
    end else begin
      exp_norm_s = ZERO_X;
    end

    if (sum_s[MW]) begin
      exp_fin_s  = exp_norm_s + ONE_X;
      frac_fin_s = sum_s[FRAC_W:1];
    end else if (!frac[FRAC_W+3] && sum_s[FRAC_W]) begin
      // denormal rounded up into the hidden bit
      exp_fin_s  = ONE_X;
      frac_fin_s = sum_s[FRAC_W-1:0];
    end else begin
      exp_fin_s  = exp_norm_s;
      frac_fin_s = sum_s[FRAC_W-1:0];
    end

    inexact  = g_s | rs_s;
    to_inf_s = (rm == RM_RNE) | ((rm == RM_RUP) & ~sign) | ((rm == RM_RDN) & sign);

    if (exp_fin_s >= MAX_X) begin
      overflow = 1'b1;
      if (to_inf_s) begin
        s = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else begin
        s = {sign, {{(EXP_W-1){1'b1}}, 1'b0}, {FRAC_W{1'b1}}};
      end
    end else begin
      overflow = 1'b0;
      s        = {sign, exp_fin_s[EXP_W-1:0], frac_fin_s};
    end
  end

endmodule

// File: rtl/fadd_norm.sv
// ---------------------------------------------------------------------------
// fadd_norm : normalize / round / pack back end of the single-precision adder.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      input bundle handshake
//   cal_frac                 raw sum {carry, hidden, frac, G, R, S}
//   temp_exp, sign, op_sub   exponent/sign of larger operand, effective sub
//   rm                       rounding mode
//   is_inf_nan, inf_nan_frac special-operand bypass and its fraction
//   out_valid / out_ready    result handshake
//   s, inexact, overflow     packed result and flags (held while out_valid)
// Build option: FADD_NORM_FAST_LZC_EN -- single-cycle normalize using a
// leading-zero count; results are identical, only latency changes.
// ---------------------------------------------------------------------------
module fadd_norm
  import fadd_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FRAC_W+4:0]      cal_frac,
  input  logic [EXP_W-1:0]       temp_exp,
  input  logic                   sign,
  input  logic                   op_sub,
  input  logic [1:0]             rm,
  input  logic                   is_inf_nan,
  input  logic [FRAC_W-1:0]      inf_nan_frac,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+FRAC_W:0]  s,
  output logic                   inexact,
  output logic                   overflow
);

  localparam int CW = FRAC_W + 5;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] ONE_X = {{(XW-1){1'b0}}, 1'b1};

  state_e                state_r, state_nxt_s;
  logic [CW-1:0]         frac_r, frac_nrm_s;
  logic [XW-1:0]         exp_r, exp_nrm_s;
  logic                  sign_r, op_sub_r, inexact_r, overflow_r;
  logic [1:0]            rm_r;
  logic [EXP_W+FRAC_W:0] s_r, rnd_pack_s;
  logic                  rnd_inexact_s, rnd_overflow_s, rnd_sign_s;
  logic                  zero_s, norm_done_s;

  assign zero_s = (frac_r == {CW{1'b0}});

`ifdef FADD_NORM_FAST_LZC_EN
  logic [XW-1:0] lz_s, max_sh_s, sh_s;

  // Whole normalization in one step: shift by min(leading zeros, exp-1).
  always_comb begin
    lz_s = XW'(CW - 1);
    for (int i = 0; i < CW - 1; i++) begin
      if (frac_r[i]) begin
        lz_s = XW'(CW - 2 - i);
      end else begin
        lz_s = lz_s;
      end
    end
    max_sh_s    = (exp_r > ONE_X) ? (exp_r - ONE_X) : {XW{1'b0}};
    sh_s        = (lz_s < max_sh_s) ? lz_s : max_sh_s;
    norm_done_s = 1'b1;
    if (frac_r[CW-1]) begin
      frac_nrm_s = {1'b0, frac_r[CW-1:2], frac_r[1] | frac_r[0]};
      exp_nrm_s  = exp_r + ONE_X;
    end else if (zero_s) begin
      frac_nrm_s = frac_r;
      exp_nrm_s  = exp_r;
    end else begin
      frac_nrm_s = frac_r << sh_s;
      exp_nrm_s  = exp_r - sh_s;
    end
  end
`else
  // One normalization action per cycle; left shifts stop at exponent 1.
  always_comb begin
    frac_nrm_s  = frac_r;
    exp_nrm_s   = exp_r;
    norm_done_s = 1'b1;
    if (frac_r[CW-1]) begin
      // carry-out: shift right, fold the dropped bit into sticky
      frac_nrm_s = {1'b0, frac_r[CW-1:2], frac_r[1] | frac_r[0]};
      exp_nrm_s  = exp_r + ONE_X;
    end else if (zero_s) begin
      norm_done_s = 1'b1;
    end else if (!frac_r[CW-2] && (exp_r > ONE_X)) begin
      frac_nrm_s  = {frac_r[CW-2:0], 1'b0};
      exp_nrm_s   = exp_r - ONE_X;
      norm_done_s = 1'b0;
    end else begin
      norm_done_s = 1'b1;
    end
  end
`endif

  // An exact zero from a subtraction takes +0 except when rounding down.
  always_comb begin
    if (zero_s && op_sub_r) begin
      rnd_sign_s = (rm_r == RM_RDN);
    end else begin
      rnd_sign_s = sign_r;
    end
  end

  fadd_round #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_round (
    .frac     (frac_r[CW-2:0]),
    .exp      (exp_r),
    .sign     (rnd_sign_s),
    .rm       (rm_r),
    .s        (rnd_pack_s),
    .inexact  (rnd_inexact_s),
    .overflow (rnd_overflow_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = is_inf_nan ? ST_DONE : ST_NORM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_NORM:  state_nxt_s = norm_done_s ? ST_ROUND : ST_NORM;
      ST_ROUND: state_nxt_s = ST_DONE;
      ST_DONE:  state_nxt_s = out_ready ? ST_IDLE : ST_DONE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: handshakes decode directly from the state register.
  always_comb begin
    in_ready  = (state_r == ST_IDLE);
    out_valid = (state_r == ST_DONE);
  end

  // Datapath registers: capture, normalize step, round result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frac_r     <= {CW{1'b0}};
      exp_r      <= {XW{1'b0}};
      sign_r     <= 1'b0;
      op_sub_r   <= 1'b0;
      rm_r       <= 2'b00;
      s_r        <= {(EXP_W+FRAC_W+1){1'b0}};
      inexact_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            frac_r   <= cal_frac;
            exp_r    <= {2'b00, temp_exp};
            sign_r   <= sign;
            op_sub_r <= op_sub;
            rm_r     <= rm;
            if (is_inf_nan) begin
              s_r        <= {sign, {EXP_W{1'b1}}, inf_nan_frac};
              inexact_r  <= 1'b0;
              overflow_r <= 1'b0;
            end
          end
        end
        ST_NORM: begin
          frac_r <= frac_nrm_s;
          exp_r  <= exp_nrm_s;
        end
        ST_ROUND: begin
          s_r        <= rnd_pack_s;
          inexact_r  <= rnd_inexact_s;
          overflow_r <= rnd_overflow_s;
        end
        ST_DONE: begin
          s_r <= s_r;
        end
        default: begin
          frac_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign s        = s_r;
  assign inexact  = inexact_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_fadd_norm.sv
// Directed, table-driven bench for fadd_norm.
module tb_fadd_norm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [27:0] cal_frac = 28'h0;
  logic [7:0]  temp_exp = 8'h0;
  logic        sign = 1'b0;
  logic        op_sub = 1'b0;
  logic [1:0]  rm = 2'b00;
  logic        is_inf_nan = 1'b0;
  logic [22:0] inf_nan_frac = 23'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] s;
  logic        inexact;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  fadd_norm dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cal_frac(cal_frac), .temp_exp(temp_exp), .sign(sign), .op_sub(op_sub),
    .rm(rm), .is_inf_nan(is_inf_nan), .inf_nan_frac(inf_nan_frac),
    .out_valid(out_valid), .out_ready(out_ready), .s(s),
    .inexact(inexact), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] cf;
    logic [7:0]  ex;
    logic        sg;
    logic        sub;
    logic [1:0]  md;
    logic        spc;
    logic [22:0] nf;
    logic [31:0] exp_s;
    logic        exp_inx;
    logic        exp_ovf;
    int          lat_ser;   // edges after the accepting edge until out_valid
    int          lat_fast;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [27:0] cf, logic [7:0] ex, logic sg, logic sub,
                              logic [1:0] md, logic spc, logic [22:0] nf,
                              logic [31:0] es, logic ei, logic eo, int ls, int lf);
    vec_t v;
    v.cf = cf; v.ex = ex; v.sg = sg; v.sub = sub; v.md = md; v.spc = spc; v.nf = nf;
    v.exp_s = es; v.exp_inx = ei; v.exp_ovf = eo; v.lat_ser = ls; v.lat_fast = lf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    cyc;
    int    lat;
    string tag;
    tag = $sformatf("v%0d", idx);
`ifdef FADD_NORM_FAST_LZC_EN
    lat = v.lat_fast;
`else
    lat = v.lat_ser;
`endif
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, "_in_ready_idle"}, {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    cal_frac = v.cf; temp_exp = v.ex; sign = v.sg; op_sub = v.sub; rm = v.md;
    is_inf_nan = v.spc; inf_nan_frac = v.nf; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 64) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_s"}, s, v.exp_s);
    chk({tag, "_inexact"}, {31'b0, inexact}, {31'b0, v.exp_inx});
    chk({tag, "_overflow"}, {31'b0, overflow}, {31'b0, v.exp_ovf});
    chk({tag, "_in_ready_busy"}, {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic seen;
    //          cal_frac      exp     sg    sub   rm     spc   nan_frac    s              inx   ovf   ser fast
    vecs.push_back(mk(28'h8000000, 8'd127, 1'b0, 1'b0, 2'b00, 1'b0, 23'h0,      32'h40000000, 1'b0, 1'b0, 2, 2));
    vecs.push_back(mk(28'h2000000, 8'd127, 1'b0, 1'b1, 2'b00, 1'b0, 23'h0,      32'h3F000000, 1'b0, 1'b0, 3, 2));
    vecs.push_back(mk(28'h0000000, 8'd127, 1'b0, 1'b1, 2'b00, 1'b0, 23'h0,      32'h00000000, 1'b0, 1'b0, 2, 2));
    vecs.push_back(mk(28'h0000000, 8'd127, 1'b0, 1'b1, 2'b10, 1'b0, 23'h0,      32'h80000000, 1'b0, 1'b0, 2, 2));
    vecs.push_back(mk(28'h0000000, 8'd5,   1'b1, 1'b0, 2'b00, 1'b0, 23'h0,      32'h80000000, 1'b0, 1'b0, 2, 2));
    vecs.push_back(mk(28'h400000C, 8'd127, 1'b0, 1'b0, 2'b00, 1'b0, 23'h0,      32'h3F800002, 1'b1, 1'b0, 2, 2));
    vecs.push_back(mk(28'h4000004, 8'd127, 1'b0, 1'b0, 2'b00, 1'b0, 23'h0,      32'h3F800000, 1'b1, 1'b0, 2, 2));
    vecs.push_back(mk(28'h8000000, 8'd254, 1'b0, 1'b0, 2'b00, 1'b0, 23'h0,      32'h7F800000, 1'b0, 1'b1, 2, 2));
    vecs.push_back(mk(28'h8000000, 8'd254, 1'b0, 1'b0, 2'b01, 1'b0, 23'h0,      32'h7F7FFFFF, 1'b0, 1'b1, 2, 2));
    vecs.push_back(mk(28'h8000000, 8'd254, 1'b0, 1'b0, 2'b10, 1'b0, 23'h0,      32'h7F7FFFFF, 1'b0, 1'b1, 2, 2));
    vecs.push_back(mk(28'h8000000, 8'd254, 1'b1, 1'b0, 2'b11, 1'b0, 23'h0,      32'hFF7FFFFF, 1'b0, 1'b1, 2, 2));
    vecs.push_back(mk(28'h8000000, 8'd254, 1'b1, 1'b0, 2'b10, 1'b0, 23'h0,      32'hFF800000, 1'b0, 1'b1, 2, 2));
    vecs.push_back(mk(28'h4000001, 8'd127, 1'b0, 1'b0, 2'b11, 1'b0, 23'h0,      32'h3F800001, 1'b1, 1'b0, 2, 2));
    vecs.push_back(mk(28'h4000001, 8'd127, 1'b1, 1'b0, 2'b10, 1'b0, 23'h0,      32'hBF800001, 1'b1, 1'b0, 2, 2));
    vecs.push_back(mk(28'h4000001, 8'd127, 1'b0, 1'b0, 2'b10, 1'b0, 23'h0,      32'h3F800000, 1'b1, 1'b0, 2, 2));
    vecs.push_back(mk(28'h4000007, 8'd127, 1'b0, 1'b0, 2'b01, 1'b0, 23'h0,      32'h3F800000, 1'b1, 1'b0, 2, 2));
    // rounding carries out of the mantissa -> exponent bump
    vecs.push_back(mk(28'h7FFFFFC, 8'd127, 1'b0, 1'b0, 2'b00, 1'b0, 23'h0,      32'h40000000, 1'b1, 1'b0, 2, 2));
    // left shifts stop at exponent 1 -> denormal result
    vecs.push_back(mk(28'h0400000, 8'd3,   1'b0, 1'b1, 2'b00, 1'b0, 23'h0,      32'h00200000, 1'b0, 1'b0, 4, 2));
    // denormal rounds up into the hidden bit -> smallest normal
    vecs.push_back(mk(28'h3FFFFFC, 8'd1,   1'b0, 1'b0, 2'b00, 1'b0, 23'h0,      32'h00800000, 1'b1, 1'b0, 2, 2));
    // special path: DONE right after the accepting edge
    vecs.push_back(mk(28'h1234567, 8'd9,   1'b1, 1'b0, 2'b00, 1'b1, 23'h0,      32'hFF800000, 1'b0, 1'b0, 0, 0));
    vecs.push_back(mk(28'h0000000, 8'd0,   1'b0, 1'b0, 2'b01, 1'b1, 23'h400000, 32'h7FC00000, 1'b0, 1'b0, 0, 0));

    // reset state
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_s", s, 32'h0);
    chk("rst_flags", {30'b0, inexact, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // back-pressure: result held stable while out_ready stays low
    @(negedge clk);
    cal_frac = 28'h8000000; temp_exp = 8'd127; sign = 1'b0; op_sub = 1'b0;
    rm = 2'b00; is_inf_nan = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 64) begin
      @(posedge clk); #1; cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_s", k), s, 32'h40000000);
      chk($sformatf("hold%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_release", {30'b0, out_valid, in_ready}, 32'd1);

    // reset while normalizing: bundle dropped, no result emitted
    @(negedge clk);
    cal_frac = 28'h0400000; temp_exp = 8'd3; sign = 1'b0; op_sub = 1'b1;
    rm = 2'b00; is_inf_nan = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_busy", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_s", s, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", {31'b0, seen}, 32'd0);

    // block still usable after the abort
    run_vec(vecs[1], 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
